// File: rtl/logic_pod_readback.sv
// Logic-analyser pod readback: streams word_count 128-bit words out of DRAM through a credit-limited FIFO.
// Optional XOR-fold checksum of delivered words is built only when LA_READBACK_CHECKSUM_EN is defined.
module logic_pod_readback #(
    parameter int FIFO_DEPTH  = 16,
    parameter int ADDR_STRIDE = 16
) (
    input  logic         clk_ram,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [28:0]  base_addr,
    input  logic [23:0]  word_count,
    output logic         busy,
    output logic         done,
    output logic         aborted,
    input  logic         ram_ready,
    output logic         ram_rd_en,
    output logic         ram_rd_valid,
    output logic [28:0]  ram_rd_addr,
    input  logic         ram_rd_ack,
    input  logic         ram_rd_data_valid,
    input  logic [127:0] ram_rd_data,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready,
    output logic [31:0]  checksum
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RAM = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_FLUSH    = 3'd4;

    logic [2:0]    r_state;
    logic [28:0]   r_addr;
    logic [23:0]   r_issue_left;
    logic [23:0]   r_xfer_left;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_fifo_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [127:0]  r_mem [FIFO_DEPTH];
    logic          r_done;
    logic          r_aborted;

    logic w_start_acc;
    logic w_abort_acc;
    logic w_active;
    logic w_credit;
    logic w_issue;
    logic w_ret;
    logic w_push;
    logic w_pop;

    assign w_start_acc = start && (r_state == S_IDLE);
    assign w_abort_acc = abort && ((r_state == S_WAIT_RAM) || (r_state == S_ISSUE) || (r_state == S_DRAIN));
    assign w_active    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    // Reads in flight plus words already buffered may never exceed the FIFO, so returns always fit.
    assign w_credit    = ({1'b0, r_outstanding} + {1'b0, r_fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign w_issue     = ram_rd_valid && ram_rd_ack;
    assign w_ret       = ram_rd_data_valid && (w_active || (r_state == S_FLUSH));
    assign w_push      = ram_rd_data_valid && w_active && !w_abort_acc;
    assign w_pop       = out_valid && out_ready;

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign aborted      = r_aborted;
    assign ram_rd_en    = (r_state == S_WAIT_RAM) || (r_state == S_ISSUE);
    assign ram_rd_valid = (r_state == S_ISSUE) && w_credit;
    assign ram_rd_addr  = r_addr;
    assign out_valid    = (r_fifo_count != '0);
    assign out_data     = r_mem[r_rd_ptr];

    always_ff @(posedge clk_ram) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_issue_left  <= '0;
            r_xfer_left   <= '0;
            r_outstanding <= '0;
            r_fifo_count  <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        if (word_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state      <= S_WAIT_RAM;
                            r_addr       <= base_addr;
                            r_issue_left <= word_count;
                            r_xfer_left  <= word_count;
                        end
                    end
                end
                S_WAIT_RAM: begin
                    if (abort)          r_state <= S_FLUSH;
                    else if (ram_ready) r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (abort)                                r_state <= S_FLUSH;
                    else if (w_issue && r_issue_left == 24'd1) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_state <= S_FLUSH;
                    end else if (w_pop && r_xfer_left == 24'd1) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (r_outstanding == '0 && r_fifo_count == '0) begin
                        r_state   <= S_IDLE;
                        r_aborted <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_issue) begin
                r_addr       <= r_addr + 29'(ADDR_STRIDE);
                r_issue_left <= r_issue_left - 24'd1;
            end
            if (w_pop && w_active) r_xfer_left <= r_xfer_left - 24'd1;

            case ({w_issue, w_ret})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_abort_acc) begin
                r_fifo_count <= '0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                    2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                    default: r_fifo_count <= r_fifo_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_ram) begin
        if (w_push) r_mem[r_wr_ptr] <= ram_rd_data;
    end

`ifdef LA_READBACK_CHECKSUM_EN
    function automatic logic [31:0] fold32(input logic [127:0] d);
        return d[127:96] ^ d[95:64] ^ d[63:32] ^ d[31:0];
    endfunction

    logic [31:0] r_checksum;

    always_ff @(posedge clk_ram) begin
        if (!rst_n)           r_checksum <= '0;
        else if (w_start_acc) r_checksum <= '0;
        else if (w_pop)       r_checksum <= r_checksum ^ fold32(out_data);
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_logic_pod_readback.sv
// Directed bench for logic_pod_readback with a 2-cycle-latency DRAM model and a stream monitor.
module tb_logic_pod_readback;
    logic         clk_ram = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [28:0]  base_addr;
    logic [23:0]  word_count;
    logic         busy;
    logic         done;
    logic         aborted;
    logic         ram_ready;
    logic         ram_rd_en;
    logic         ram_rd_valid;
    logic [28:0]  ram_rd_addr;
    logic         ram_rd_ack;
    logic         ram_rd_data_valid;
    logic [127:0] ram_rd_data;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;
    logic [31:0]  checksum;

    logic_pod_readback #(.FIFO_DEPTH(16), .ADDR_STRIDE(16)) dut (
        .clk_ram(clk_ram), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .aborted(aborted),
        .ram_ready(ram_ready), .ram_rd_en(ram_rd_en), .ram_rd_valid(ram_rd_valid),
        .ram_rd_addr(ram_rd_addr), .ram_rd_ack(ram_rd_ack),
        .ram_rd_data_valid(ram_rd_data_valid), .ram_rd_data(ram_rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .checksum(checksum)
    );

    always #5 clk_ram = ~clk_ram;

    int n_cmp = 0;
    int n_err = 0;
    int n_ack = 0;
    int n_done = 0;
    int n_abt = 0;
    int n_issued = 0;
    int ack_limit = 1000000;
    logic busy_at_done = 1'b1;
    logic ovr = 1'b0;
    logic [127:0] ovr_tab [2];
    logic [28:0]  q_addr [$];
    logic [127:0] q_data [$];

    function automatic logic [127:0] ram_word(input logic [28:0] a);
        logic [31:0] x;
        x = {3'b000, a};
        return {x ^ 32'hC0DE0000, x, ~x, x + 32'h12345678};
    endfunction

    function automatic logic [28:0] qa(input int i);
        if (q_addr.size() > i) return q_addr[i];
        return 29'h1ABCDEF5;
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ram);
        #1;
    endtask

    task automatic clear_logs();
        q_addr.delete();
        q_data.delete();
        n_ack = 0;
        n_done = 0;
        n_abt = 0;
        n_issued = 0;
        busy_at_done = 1'b1;
    endtask

    task automatic run_start(input logic [28:0] b, input logic [23:0] c);
        base_addr = b;
        word_count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max && n_done == 0; i++) tick();
    endtask

    // DRAM model: acks whenever valid (up to ack_limit), returns data two cycles after the ack.
    initial begin
        logic         p0_v, p1_v;
        logic [127:0] p0_d, p1_d;
        p0_v = 1'b0; p1_v = 1'b0; p0_d = '0; p1_d = '0;
        ram_rd_ack = 1'b0;
        ram_rd_data_valid = 1'b0;
        ram_rd_data = '0;
        forever begin
            @(posedge clk_ram);
            #2;
            ram_rd_data_valid = p1_v;
            ram_rd_data = p1_d;
            p1_v = p0_v;
            p1_d = p0_d;
            ram_rd_ack = ram_rd_valid && (n_issued < ack_limit);
            p0_v = ram_rd_ack;
            p0_d = ovr ? ovr_tab[n_issued % 2] : ram_word(ram_rd_addr);
            if (ram_rd_ack) n_issued++;
        end
    end

    always @(negedge clk_ram) begin
        if (rst_n) begin
            if (ram_rd_valid && ram_rd_ack) begin
                q_addr.push_back(ram_rd_addr);
                n_ack++;
            end
            if (out_valid && out_ready) q_data.push_back(out_data);
            if (done) begin
                n_done++;
                busy_at_done = busy;
            end
            if (aborted) n_abt++;
        end
    end

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; word_count = '0;
        ram_ready = 1'b0; out_ready = 1'b0;
        ovr_tab[0] = '0; ovr_tab[1] = '0;
        repeat (3) tick();
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done_abt", {done, aborted}, 2'b00);
        check_val("rst_en_valid", {ram_rd_en, ram_rd_valid}, 2'b00);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_addr", ram_rd_addr, 29'h0);
        check_val("rst_checksum", checksum, 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic 4-word readback, plus a start while busy that must be ignored
        clear_logs();
        ram_ready = 1'b1; out_ready = 1'b1;
        run_start(29'h100, 24'd4);
        check_val("a_busy_after_start", busy, 1'b1);
        run_start(29'h5000, 24'd9);
        wait_done(100);
        check_val("a_ack_count", n_ack, 4);
        for (int i = 0; i < 4; i++) check_val($sformatf("a_addr%0d", i), qa(i), 29'h100 + 29'(16 * i));
        check_val("a_words", q_data.size(), 4);
        bad = 0;
        for (int i = 0; i < q_data.size(); i++)
            if (q_data[i] !== ram_word(29'h100 + 29'(16 * i))) bad++;
        check_val("a_word_data", bad, 0);
        check_val("a_busy_at_done", busy_at_done, 1'b0);
`ifndef LA_READBACK_CHECKSUM_EN
        check_val("a_checksum_tied", checksum, 32'h0);
`endif
        repeat (5) tick();
        check_val("a_single_done", n_done, 1);

        // Zero-length start: done next cycle, never busy, no reads
        clear_logs();
        run_start(29'h300, 24'd0);
        check_val("z_done_pulse", done, 1'b1);
        check_val("z_busy", busy, 1'b0);
        tick();
        check_val("z_done_drop", done, 1'b0);
        check_val("z_no_acks", n_ack, 0);

        // Abort in IDLE is ignored
        clear_logs();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("i_abort_ignored", {aborted, busy}, 2'b00);
        repeat (3) tick();
        check_val("i_no_aborted", n_abt, 0);

        // 40 words with the consumer stalled: credit caps issue at the FIFO depth
        clear_logs();
        out_ready = 1'b0;
        run_start(29'h2000, 24'd40);
        repeat (200) tick();
        check_val("s_acks_capped", n_ack, 16);
        check_val("s_valid_stalled", ram_rd_valid, 1'b0);
        check_val("s_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_done(400);
        check_val("s_total_acks", n_ack, 40);
        check_val("s_words", q_data.size(), 40);
        bad = 0;
        for (int i = 0; i < q_data.size(); i++)
            if (q_data[i] !== ram_word(29'h2000 + 29'(16 * i))) bad++;
        check_val("s_word_data", bad, 0);
        check_val("s_done_count", n_done, 1);

        // Abort after 3 acks with 2 returns still pending
        clear_logs();
        out_ready = 1'b0;
        ack_limit = 3;
        run_start(29'h400, 24'd8);
        for (int i = 0; i < 50 && n_ack < 3; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("f_busy_in_flush", busy, 1'b1);
        check_val("f_en_valid_drop", {ram_rd_en, ram_rd_valid}, 2'b00);
        check_val("f_out_valid_clr", out_valid, 1'b0);
        for (int i = 0; i < 50 && n_abt == 0; i++) tick();
        check_val("f_aborted", n_abt, 1);
        check_val("f_busy_after", busy, 1'b0);
        out_ready = 1'b1;
        repeat (5) tick();
        check_val("f_no_done", n_done, 0);
        check_val("f_acks", n_ack, 3);
        check_val("f_no_words", q_data.size(), 0);
        ack_limit = 1000000;

        // Address wrap at the top of the 29-bit space; also proves the FIFO came back clean
        clear_logs();
        run_start(29'h1FFFFFF0, 24'd2);
        wait_done(100);
        check_val("w_addr0", qa(0), 29'h1FFFFFF0);
        check_val("w_addr1", qa(1), 29'h0000000);
        check_val("w_words", q_data.size(), 2);
        bad = 0;
        for (int i = 0; i < q_data.size(); i++)
            if (q_data[i] !== ram_word(i == 0 ? 29'h1FFFFFF0 : 29'h0)) bad++;
        check_val("w_word_data", bad, 0);

        // DRAM not calibrated for 50 cycles
        clear_logs();
        ram_ready = 1'b0;
        run_start(29'h800, 24'd2);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!(ram_rd_en === 1'b1 && ram_rd_valid === 1'b0)) bad++;
        end
        check_val("r_wait_en_no_valid", bad, 0);
        check_val("r_no_acks", n_ack, 0);
        ram_ready = 1'b1;
        tick();
        check_val("r_valid_after_ready", ram_rd_valid, 1'b1);
        wait_done(100);
        check_val("r_acks", n_ack, 2);
        check_val("r_done", n_done, 1);

        // Reset mid-operation abandons everything silently
        clear_logs();
        run_start(29'hA00, 24'd8);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check_val("m_busy", busy, 1'b0);
        check_val("m_out_valid", out_valid, 1'b0);
        check_val("m_addr", ram_rd_addr, 29'h0);
        rst_n = 1'b1;
        repeat (10) tick();
        check_val("m_no_pulses", {n_done[7:0], n_abt[7:0]}, 16'h0);

`ifdef LA_READBACK_CHECKSUM_EN
        clear_logs();
        ovr = 1'b1;
        ovr_tab[0] = 128'h00000001_00000002_00000004_00000008;
        ovr_tab[1] = {128{1'b1}};
        run_start(29'hC00, 24'd2);
        wait_done(100);
        check_val("c_checksum", checksum, 32'h0000000F);
        repeat (5) tick();
        check_val("c_checksum_hold", checksum, 32'h0000000F);
        ovr = 1'b0;
        run_start(29'hC00, 24'd0);
        check_val("c_checksum_clr", checksum, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
